// File: rtl/next_mon_pkg.sv
// rtl/next_mon_pkg.sv - shared types and default link constants for the NeXT monitor link
// Contents: state_t (host FSM states), DEF_* defaults shared with the sound-box side.
package next_mon_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      SHIFT      = 3'd2,
      WAIT_REPLY = 3'd3,
      RX_SHIFT   = 3'd4,
      GAP        = 3'd5
   } state_t;

   localparam int DEF_HALF_DIV = 3;    // 27 MHz / 6 = 4.5 MHz link clock
   localparam int DEF_TX_BITS  = 24;
   localparam int DEF_RX_BITS  = 24;
   localparam int DEF_TIMEOUT  = 64;
   localparam int DEF_GAP      = 4;

endpackage

// File: rtl/next_mon_clkgen.sv
// rtl/next_mon_clkgen.sv - free-running link clock divider with edge strobes
// Ports:
//   clk, reset : system clock, async active-high reset
//   mon_clk    : link clock, toggles every HALF_DIV clk cycles
//   rise_en    : high in the clk cycle whose edge registers mon_clk 0->1
//   fall_en    : high in the clk cycle whose edge registers mon_clk 1->0
module next_mon_clkgen
   import next_mon_pkg::*;
#(
   parameter int HALF_DIV = DEF_HALF_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic mon_clk,
   output logic rise_en,
   output logic fall_en
);

   localparam int CW = $clog2(HALF_DIV);

   logic [CW-1:0] cnt;
   logic          term;

   assign term    = (cnt == CW'(HALF_DIV - 1));
   assign rise_en = term && !mon_clk;
   assign fall_en = term && mon_clk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         mon_clk <= 1'b0;
      end else if (term) begin
         cnt     <= '0;
         mon_clk <= ~mon_clk;
      end else begin
         cnt     <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/next_mon_host.sv
// rtl/next_mon_host.sv - host end of the NeXT monitor/sound-box serial link
// Ports:
//   clk, reset              : system clock, async active-high reset
//   tx_data/tx_valid/tx_ready : command frame in, MSB first; accepted only in IDLE
//   expect_reply            : sampled at accept, 1 = collect a reply frame
//   rx_data/rx_valid        : last reply payload, 1-cycle pulse on update
//   rx_timeout              : 1-cycle pulse when no reply start bit arrives
//   busy                    : high whenever not IDLE
//   mon_clk/to_mon/from_mon : link pins; to_mon and from_mon idle high
module next_mon_host
   import next_mon_pkg::*;
#(
   parameter int HALF_DIV = DEF_HALF_DIV,
   parameter int TX_BITS  = DEF_TX_BITS,
   parameter int RX_BITS  = DEF_RX_BITS,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int GAP_N    = DEF_GAP
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [TX_BITS-1:0] tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   input  logic               expect_reply,
   output logic [RX_BITS-1:0] rx_data,
   output logic               rx_valid,
   output logic               rx_timeout,
   output logic               busy,
   output logic               mon_clk,
   output logic               to_mon,
   input  logic               from_mon
);

   localparam int TXC_W = $clog2(TX_BITS + 1);
   localparam int RXC_W = $clog2(RX_BITS + 1);
   localparam int TOC_W = $clog2(TIMEOUT + 1);
   localparam int GPC_W = $clog2(GAP_N + 1);

   state_t             state, state_nx;
   logic               rise_en, fall_en;
   logic               from_s1, from_s2;
   logic [TX_BITS-1:0] tx_sh;
   logic               exp_reply;
   logic [TXC_W-1:0]   bit_cnt;
   logic [TOC_W-1:0]   wait_cnt;
   logic [RXC_W-1:0]   rx_cnt;
   logic [GPC_W-1:0]   gap_cnt;
   logic [RX_BITS-2:0] rx_sh;
   logic [RX_BITS-1:0] rx_nx;

   logic load, drv_start, drv_bit, drv_stop, wait_step;
   logic timeout_hit, rx_step, rx_last, gap_step;

   next_mon_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
      .clk     (clk),
      .reset   (reset),
      .mon_clk (mon_clk),
      .rise_en (rise_en),
      .fall_en (fall_en)
   );

   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign rx_nx    = {rx_sh, from_s2};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      load        = 1'b0;
      drv_start   = 1'b0;
      drv_bit     = 1'b0;
      drv_stop    = 1'b0;
      wait_step   = 1'b0;
      timeout_hit = 1'b0;
      rx_step     = 1'b0;
      rx_last     = 1'b0;
      gap_step    = 1'b0;
      case (state)
         IDLE: if (tx_valid) begin
            load     = 1'b1;
            state_nx = START;
         end
         START: if (fall_en) begin
            drv_start = 1'b1;
            state_nx  = SHIFT;
         end
         SHIFT: if (fall_en) begin
            if (bit_cnt == TXC_W'(TX_BITS)) begin
               drv_stop = 1'b1;
               state_nx = exp_reply ? WAIT_REPLY : GAP;
            end else begin
               drv_bit = 1'b1;
            end
         end
         // A start bit on the final counted edge takes priority over timeout.
         WAIT_REPLY: if (rise_en) begin
            if (!from_s2) begin
               state_nx = RX_SHIFT;
            end else if (wait_cnt == TOC_W'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_nx    = GAP;
            end else begin
               wait_step = 1'b1;
            end
         end
         RX_SHIFT: if (rise_en) begin
            rx_step = 1'b1;
            if (rx_cnt == RXC_W'(RX_BITS - 1)) begin
               rx_last  = 1'b1;
               state_nx = GAP;
            end
         end
         GAP: if (fall_en) begin
            if (gap_cnt == GPC_W'(GAP_N - 1)) state_nx = IDLE;
            else                              gap_step = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         from_s1    <= 1'b1;
         from_s2    <= 1'b1;
         to_mon     <= 1'b1;
         tx_sh      <= '0;
         exp_reply  <= 1'b0;
         bit_cnt    <= '0;
         wait_cnt   <= '0;
         rx_cnt     <= '0;
         gap_cnt    <= '0;
         rx_sh      <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_timeout <= 1'b0;
      end else begin
         from_s1    <= from_mon;
         from_s2    <= from_s1;
         rx_valid   <= rx_last;
         rx_timeout <= timeout_hit;
         if (load) begin
            tx_sh     <= tx_data;
            exp_reply <= expect_reply;
         end
         if (drv_start) begin
            to_mon  <= 1'b0;
            bit_cnt <= '0;
         end
         if (drv_bit) begin
            to_mon  <= tx_sh[TX_BITS-1];
            tx_sh   <= {tx_sh[TX_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
         end
         // Stop bit clears every post-frame counter so both GAP entry paths start at zero.
         if (drv_stop) begin
            to_mon   <= 1'b1;
            wait_cnt <= '0;
            rx_cnt   <= '0;
            gap_cnt  <= '0;
         end
         if (wait_step) wait_cnt <= wait_cnt + 1'b1;
         if (rx_step) begin
            rx_sh  <= rx_nx[RX_BITS-2:0];
            rx_cnt <= rx_cnt + 1'b1;
         end
         if (rx_last) rx_data <= rx_nx;
         if (gap_step) gap_cnt <= gap_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_next_mon_host.sv
// tb/tb_next_mon_host.sv - directed self-checking bench for next_mon_host
module tb_next_mon_host;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        expect_reply;
   logic [23:0] rx_data;
   logic        rx_valid;
   logic        rx_timeout;
   logic        busy;
   logic        mon_clk;
   logic        to_mon;
   logic        from_mon;

   always #5 clk = ~clk;

   next_mon_host dut (
      .clk          (clk),
      .reset        (reset),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .expect_reply (expect_reply),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_timeout   (rx_timeout),
      .busy         (busy),
      .mon_clk      (mon_clk),
      .to_mon       (to_mon),
      .from_mon     (from_mon)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // to_mon may only change on the clk edge where mon_clk falls.
   int   bad_change = 0;
   bit   chk_en = 1'b0;
   logic ob_pm = 1'b0;
   logic ob_pt = 1'b1;
   always @(negedge clk) begin
      if (chk_en && (to_mon !== ob_pt) && !(ob_pm === 1'b1 && mon_clk === 1'b0))
         bad_change <= bad_change + 1;
      ob_pm <= mon_clk;
      ob_pt <= to_mon;
   end

   int   cyc = 0;
   int   fall_no = 0;
   logic pmc = 1'b0;
   bit   m_fall, m_rise;

   task automatic tick();
      @(negedge clk);
      cyc++;
      m_fall = (pmc === 1'b1 && mon_clk === 1'b0);
      m_rise = (pmc === 1'b0 && mon_clk === 1'b1);
      if (m_fall) fall_no++;
      pmc = mon_clk;
   endtask

   logic [23:0] got;
   logic        got_stop;
   int start_f, start_cyc, stop_cyc, acc_cyc, ready_cyc;
   int rxv_n, rxt_n, rxv_cyc, rxt_cyc, hold_bad;

   task automatic frame_run(input logic [23:0] d, input logic er, input bit do_reply,
                            input logic [23:0] rep, input bit hold, input logic [23:0] nxt);
      int k;
      logic last_bit;
      logic [4:0] bi;
      got = '0; got_stop = 1'b0; start_f = -1; start_cyc = -1; stop_cyc = -1;
      ready_cyc = -1; rxv_n = 0; rxt_n = 0; rxv_cyc = -1; rxt_cyc = -1; hold_bad = 0;
      last_bit = 1'b1;
      tx_data = d; expect_reply = er; tx_valid = 1'b1;
      chk("ready_at_accept", 32'(tx_ready), 32'd1);
      tick();
      acc_cyc = cyc;
      if (!hold) tx_valid = 1'b0;
      for (int n = 0; n < 2000 && ready_cyc < 0; n++) begin
         tick();
         if (rx_valid === 1'b1) begin rxv_n++; if (rxv_cyc < 0) rxv_cyc = cyc; end
         if (rx_timeout === 1'b1) begin rxt_n++; if (rxt_cyc < 0) rxt_cyc = cyc; end
         if (start_f < 0) begin
            if (m_fall && to_mon === 1'b0) begin
               start_f = fall_no; start_cyc = cyc; last_bit = 1'b0;
            end
         end else begin
            k = fall_no - start_f;
            if (m_fall) begin
               if (k >= 1 && k <= 24) got = {got[22:0], to_mon};
               if (k == 25) begin got_stop = to_mon; stop_cyc = cyc; end
               last_bit = to_mon;
               if (hold && k == 12) tx_data = nxt;
               if (do_reply) begin
                  if (k == 30) from_mon = 1'b0;
                  else if (k >= 31 && k <= 54) begin bi = 5'(54 - k); from_mon = rep[bi]; end
                  else if (k == 55) from_mon = 1'b1;
               end
            end
            if (m_rise && to_mon !== last_bit) hold_bad++;
            if (tx_ready === 1'b1) ready_cyc = cyc;
         end
      end
      from_mon = 1'b1;
   endtask

   int f1_start;
   int bc0;
   logic [11:0] pat;
   int lim;

   initial begin
      reset = 1'b1; tx_data = '0; tx_valid = 1'b0; expect_reply = 1'b0; from_mon = 1'b1;
      tick(); tick();
      chk("rst_mon_clk", 32'(mon_clk), 32'd0);
      chk("rst_to_mon", 32'(to_mon), 32'd1);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_timeout", 32'(rx_timeout), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      reset = 1'b0;
      pmc = mon_clk;
      pat = '0;
      for (int i = 0; i < 12; i++) begin tick(); pat = {pat[10:0], mon_clk}; end
      chk("mon_clk_pattern", 32'(pat), 32'b001110001110);
      chk("idle_to_mon", 32'(to_mon), 32'd1);
      chk("idle_tx_ready", 32'(tx_ready), 32'd1);
      chk("idle_rx_valid", 32'(rx_valid), 32'd0);
      chk("idle_rx_timeout", 32'(rx_timeout), 32'd0);
      chk_en = 1'b1;
      bc0 = bad_change;

      // Plain command, no reply
      frame_run(24'hA5C3F0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
      chk("tx1_data", 32'(got), 32'hA5C3F0);
      chk("tx1_stop", 32'(got_stop), 32'd1);
      chk("tx1_ready_window", 32'((ready_cyc - acc_cyc >= 174) && (ready_cyc - acc_cyc <= 186)), 32'd1);
      chk("tx1_no_rx_valid", 32'(rxv_n), 32'd0);
      chk("tx1_no_timeout", 32'(rxt_n), 32'd0);
      chk("tx1_bit_hold", 32'(hold_bad), 32'd0);

      // Command with reply start + 0x123456 five periods after the stop bit
      frame_run(24'hA5C3F0, 1'b1, 1'b1, 24'h123456, 1'b0, 24'h0);
      chk("tx2_data", 32'(got), 32'hA5C3F0);
      chk("rx2_valid_count", 32'(rxv_n), 32'd1);
      chk("rx2_data", 32'(rx_data), 32'h123456);
      chk("rx2_valid_time", 32'(rxv_cyc - stop_cyc), 32'd177);
      chk("rx2_no_timeout", 32'(rxt_n), 32'd0);
      chk("rx2_gap_window", 32'((ready_cyc - rxv_cyc >= 18) && (ready_cyc - rxv_cyc <= 30)), 32'd1);

      // Reply expected, none arrives
      frame_run(24'h0F0F0F, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
      chk("to3_data", 32'(got), 32'h0F0F0F);
      chk("to3_timeout_count", 32'(rxt_n), 32'd1);
      chk("to3_timeout_time", 32'(rxt_cyc - stop_cyc), 32'd381);
      chk("to3_no_rx_valid", 32'(rxv_n), 32'd0);
      chk("to3_rx_data_kept", 32'(rx_data), 32'h123456);

      // Back-to-back with tx_valid held and data changing while busy
      frame_run(24'h111111, 1'b0, 1'b0, 24'h0, 1'b1, 24'h5A5A5A);
      f1_start = start_f;
      chk("b2b1_data", 32'(got), 32'h111111);
      frame_run(24'h5A5A5A, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
      chk("b2b2_data", 32'(got), 32'h5A5A5A);
      chk("b2b_idle_periods", 32'(start_f - (f1_start + 25) - 1), 32'd4);
      chk("to_mon_only_at_fall", 32'(bad_change - bc0), 32'd0);

      // Reset in the middle of SHIFT
      tx_data = 24'h000000; expect_reply = 1'b0; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      start_f = -1;
      lim = 0;
      while (start_f < 0 && lim < 100) begin
         tick(); lim++;
         if (m_fall && to_mon === 1'b0) start_f = fall_no;
      end
      lim = 0;
      while (fall_no - start_f < 10 && lim < 200) begin tick(); lim++; end
      tick(); tick(); tick();
      chk("pre_rst_mon_clk", 32'(mon_clk), 32'd1);
      chk("pre_rst_to_mon", 32'(to_mon), 32'd0);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      chk_en = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_to_mon", 32'(to_mon), 32'd1);
      chk("mid_rst_mon_clk", 32'(mon_clk), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
      tick(); tick();
      reset = 1'b0;
      pmc = mon_clk;
      tick(); tick();
      chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);
      chk_en = 1'b1;
      bc0 = bad_change;
      frame_run(24'h000001, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
      chk("post_rst_data", 32'(got), 32'h000001);
      chk("post_rst_stop", 32'(got_stop), 32'd1);
      chk("post_rst_ready_window", 32'((ready_cyc - acc_cyc >= 174) && (ready_cyc - acc_cyc <= 186)), 32'd1);
      chk("post_rst_only_at_fall", 32'(bad_change - bc0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
